// File: rtl/asteroid_reader.sv
// Reads the one-hot asteroid position, erases the old pixel and draws the new one
// through a valid/ready plotter port, then checks for a collision with the ship.
module asteroid_reader #(
    parameter logic [2:0] DRAW_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [159:0] asteroid_x,
    input  logic [119:0] asteroid_y,
    input  logic [7:0]   ship_x,
    input  logic [6:0]   ship_y,
    input  logic         plot_ready,
    output logic [7:0]   plot_x,
    output logic [6:0]   plot_y,
    output logic [2:0]   plot_colour,
    output logic         plot_valid,
    output logic [7:0]   cur_x,
    output logic [6:0]   cur_y,
    output logic         drawn,
    output logic         hit,
    output logic [3:0]   hit_count,
    output logic         fmt_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ERASE = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;
    localparam logic [1:0] CHECK = 2'd3;

    logic [1:0] state;
    logic [7:0] pend_x;
    logic [6:0] pend_y;
    logic       has_pend;

    logic [7:0] dec_x;
    logic [6:0] dec_y;
    logic       x_zero, y_zero, x_multi, y_multi, pos_valid, pos_moved;

    // Descending scan so the lowest set bit wins.
    always_comb begin
        dec_x = '0;
        for (int i = 159; i >= 0; i--)
            if (asteroid_x[i]) dec_x = 8'(i);
        dec_y = '0;
        for (int i = 119; i >= 0; i--)
            if (asteroid_y[i]) dec_y = 7'(i);
    end

    assign x_zero    = (asteroid_x == '0);
    assign y_zero    = (asteroid_y == '0);
    assign x_multi   = ((asteroid_x & (asteroid_x - 160'd1)) != '0);
    assign y_multi   = ((asteroid_y & (asteroid_y - 120'd1)) != '0);
    assign pos_valid = !x_zero && !y_zero && !x_multi && !y_multi;
    assign pos_moved = !drawn || (dec_x != cur_x) || (dec_y != cur_y);

    // Plot port is decoded from state so a reset drops it without waiting for a clock.
    always_comb begin
        plot_valid  = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = '0;
        if (state == ERASE) begin
            plot_valid  = 1'b1;
            plot_x      = cur_x;
            plot_y      = cur_y;
            plot_colour = BG_COLOUR;
        end else if (state == DRAW) begin
            plot_valid  = 1'b1;
            plot_x      = pend_x;
            plot_y      = pend_y;
            plot_colour = DRAW_COLOUR;
        end
    end

    assign hit = (state == CHECK) && (cur_x == ship_x) && (cur_y == ship_y);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend_x    <= '0;
            pend_y    <= '0;
            has_pend  <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            drawn     <= 1'b0;
            hit_count <= '0;
            fmt_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_multi || y_multi) fmt_err <= 1'b1;
                    if (pos_valid && pos_moved) begin
                        pend_x   <= dec_x;
                        pend_y   <= dec_y;
                        has_pend <= 1'b1;
                        state    <= drawn ? ERASE : DRAW;
                    end else if (!pos_valid && drawn) begin
                        has_pend <= 1'b0;
                        state    <= ERASE;
                    end
                end
                ERASE: begin
                    if (plot_ready) begin
                        if (has_pend) begin
                            state <= DRAW;
                        end else begin
                            drawn <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DRAW: begin
                    if (plot_ready) begin
                        cur_x    <= pend_x;
                        cur_y    <= pend_y;
                        drawn    <= 1'b1;
                        has_pend <= 1'b0;
                        state    <= CHECK;
                    end
                end
                default: begin
                    if (hit && hit_count != 4'd15) hit_count <= hit_count + 4'd1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asteroid_reader.sv
// Directed bench for asteroid_reader: a table of moves plus hand sequences for
// stall, latency, hit saturation and reset during a draw.
module tb_asteroid_reader;

    logic         clock = 1'b0;
    logic         reset;
    logic [159:0] asteroid_x;
    logic [119:0] asteroid_y;
    logic [7:0]   ship_x;
    logic [6:0]   ship_y;
    logic         plot_ready;
    logic [7:0]   plot_x;
    logic [6:0]   plot_y;
    logic [2:0]   plot_colour;
    logic         plot_valid;
    logic [7:0]   cur_x;
    logic [6:0]   cur_y;
    logic         drawn;
    logic         hit;
    logic [3:0]   hit_count;
    logic         fmt_err;

    asteroid_reader dut (
        .clock(clock), .reset(reset),
        .asteroid_x(asteroid_x), .asteroid_y(asteroid_y),
        .ship_x(ship_x), .ship_y(ship_y), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot_valid(plot_valid),
        .cur_x(cur_x), .cur_y(cur_y), .drawn(drawn),
        .hit(hit), .hit_count(hit_count), .fmt_err(fmt_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Handshake monitor, sampled mid-cycle; handshake completes on the following posedge.
    int ecnt = 0, dcnt = 0, hcnt = 0;
    int last_ex = -1, last_ey = -1, last_dx = -1, last_dy = -1;
    always @(negedge clock) begin
        if (reset && plot_valid && plot_ready) begin
            if (plot_colour == 3'b000) begin
                ecnt++; last_ex = int'(plot_x); last_ey = int'(plot_y);
            end else begin
                dcnt++; last_dx = int'(plot_x); last_dy = int'(plot_y);
            end
        end
        if (hit) hcnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ax/ay: index of the single set bit, -1 = all zero, -2 = bits 5 and 9
    task automatic set_pos(input int ax, input int ay, input int sx, input int sy);
        logic [159:0] vx;
        logic [119:0] vy;
        vx = '0; vy = '0;
        if (ax >= 0) vx[ax] = 1'b1;
        else if (ax == -2) begin vx[5] = 1'b1; vx[9] = 1'b1; end
        if (ay >= 0) vy[ay] = 1'b1;
        asteroid_x = vx;
        asteroid_y = vy;
        ship_x = 8'(sx);
        ship_y = 7'(sy);
    endtask

    typedef struct {
        int ax, ay, sx, sy;
        int n_erase, n_draw, ex, ey;
        int cx, cy, drw, hc, fe;
    } rec_t;

    rec_t tbl[10];

    initial begin
        int e0, d0, h0;
        reset = 1'b0;
        plot_ready = 1'b1;
        set_pos(-1, -1, 255, 127);

        tbl[0] = '{23, 119, 255, 127, 0, 1, -1, -1, 23, 119, 1, 0, 0};
        tbl[1] = '{23, 119, 255, 127, 0, 0, -1, -1, 23, 119, 1, 0, 0};
        tbl[2] = '{159, 10, 255, 127, 1, 1, 23, 119, 159, 10, 1, 0, 0};
        tbl[3] = '{0,   10, 255, 127, 1, 1, 159, 10, 0,  10, 1, 0, 0};
        tbl[4] = '{0,   40, 255, 127, 1, 1, 0,   10, 0,  40, 1, 0, 0};
        tbl[5] = '{-1,  40, 255, 127, 1, 0, 0,   40, 0,  40, 0, 0, 0};
        tbl[6] = '{-1,  40, 255, 127, 0, 0, -1,  -1, 0,  40, 0, 0, 0};
        tbl[7] = '{69,  60, 69,  60,  0, 1, -1,  -1, 69, 60, 1, 1, 0};
        tbl[8] = '{-2,  60, 255, 127, 1, 0, 69,  60, 69, 60, 0, 1, 1};
        tbl[9] = '{7,    7, 255, 127, 0, 1, -1,  -1, 7,  7,  1, 1, 1};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_plot_valid", int'(plot_valid), 0);
        chk("rst_plot_x", int'(plot_x), 0);
        chk("rst_plot_colour", int'(plot_colour), 0);
        chk("rst_drawn", int'(drawn), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_fmt_err", int'(fmt_err), 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            e0 = ecnt; d0 = dcnt;
            set_pos(tbl[i].ax, tbl[i].ay, tbl[i].sx, tbl[i].sy);
            repeat (8) @(posedge clock);
            #1;
            chk($sformatf("v%0d_erases", i), ecnt - e0, tbl[i].n_erase);
            chk($sformatf("v%0d_draws", i), dcnt - d0, tbl[i].n_draw);
            if (tbl[i].n_erase > 0) begin
                chk($sformatf("v%0d_erase_x", i), last_ex, tbl[i].ex);
                chk($sformatf("v%0d_erase_y", i), last_ey, tbl[i].ey);
            end
            chk($sformatf("v%0d_cur_x", i), int'(cur_x), tbl[i].cx);
            chk($sformatf("v%0d_cur_y", i), int'(cur_y), tbl[i].cy);
            chk($sformatf("v%0d_drawn", i), int'(drawn), tbl[i].drw);
            chk($sformatf("v%0d_hit_count", i), int'(hit_count), tbl[i].hc);
            chk($sformatf("v%0d_fmt_err", i), int'(fmt_err), tbl[i].fe);
        end

        // Move with plotter stall: (23,119) -> (23,118), ready low for 3 ERASE cycles
        set_pos(23, 119, 255, 127);
        repeat (8) @(posedge clock);
        #1;
        e0 = ecnt;
        plot_ready = 1'b0;
        set_pos(23, 118, 255, 127);
        @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_valid", k), int'(plot_valid), 1);
            chk($sformatf("stall%0d_xy", k), int'({plot_x, plot_y}), int'({8'd23, 7'd119}));
            chk($sformatf("stall%0d_colour", k), int'(plot_colour), 0);
            set_pos(1, 1, 255, 127);
            @(posedge clock); #1;
        end
        plot_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("stall_draw_colour", int'(plot_colour), 7);
        chk("stall_draw_xy", int'({plot_x, plot_y}), int'({8'd23, 7'd118}));
        set_pos(23, 118, 255, 127);
        repeat (4) @(posedge clock);
        #1;
        chk("stall_erases", ecnt - e0, 1);
        chk("stall_cur_y", int'(cur_y), 118);

        // Latency from drawn=1 and single-cycle hit pulse in CHECK
        set_pos(69, 60, 69, 60);
        @(negedge clock);
        chk("lat0_valid", int'(plot_valid), 0);
        @(posedge clock); @(negedge clock);
        chk("lat1_erase", int'({plot_valid, plot_colour}), 8);
        @(posedge clock); @(negedge clock);
        chk("lat2_draw", int'({plot_valid, plot_colour}), 15);
        chk("lat2_x", int'(plot_x), 69);
        @(posedge clock); @(negedge clock);
        chk("lat3_check", int'({plot_valid, hit}), 1);
        @(posedge clock); @(negedge clock);
        chk("lat4_idle", int'({plot_valid, hit}), 0);
        chk("lat_hit_count", int'(hit_count), 2);

        // Hit saturation: 16 more hits
        h0 = hcnt;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            if (i % 2 == 0) set_pos(70, 60, 70, 60);
            else            set_pos(69, 60, 69, 60);
            repeat (6) @(posedge clock);
        end
        #1;
        chk("sat_hits", hcnt - h0, 16);
        chk("sat_hit_count", int'(hit_count), 15);

        // Reset while a DRAW is stalled
        @(posedge clock); #1;
        set_pos(10, 10, 255, 127);
        @(posedge clock); #1;
        @(posedge clock); #1;
        plot_ready = 1'b0;
        @(posedge clock); #1;
        chk("mid_draw_valid", int'({plot_valid, plot_colour}), 15);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", int'(plot_valid), 0);
        chk("mid_rst_drawn", int'(drawn), 0);
        chk("mid_rst_hit_count", int'(hit_count), 0);
        chk("mid_rst_fmt_err", int'(fmt_err), 0);
        chk("mid_rst_cur_x", int'(cur_x), 0);
        @(posedge clock); #1;
        e0 = ecnt; d0 = dcnt;
        reset = 1'b1;
        plot_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("post_rst_erases", ecnt - e0, 0);
        chk("post_rst_draws", dcnt - d0, 1);
        chk("post_rst_cur", int'({cur_x, cur_y}), int'({8'd10, 7'd10}));
        chk("post_rst_drawn", int'(drawn), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
